// File: rtl/crack_sequencer.sv
// Password-crack controller: loads a target hash, then runs a dictionary pass and (with CRACK_BRUTE_EN) a brute-force pass.
// Single outstanding hash request; abort returns to IDLE with attempts frozen.
module crack_sequencer #(
   parameter int DATA_W     = 128,
   parameter int ADDR_W     = 8,
   parameter int DICT_START = 1,
   parameter int DICT_SIZE  = 3,
   parameter int BRUTE_MAX  = 10,
   parameter int MEM_LAT    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              hash_req,
   input  logic              hash_ack,
   output logic [DATA_W-1:0] hash_in,
   input  logic              hash_valid,
   input  logic [DATA_W-1:0] hash_out,
   output logic [2:0]        state,
   output logic [2:0]        led,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [DATA_W-1:0] found_word,
   output logic [31:0]       attempts
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_LOAD = 3'd1, S_DICT = 3'd2,
      S_BRUTE = 3'd3, S_SUCCESS = 3'd4, S_FAIL = 3'd5
   } state_t;

   // Sub-step within LOAD/DICT/BRUTE: issue read, wait for data, request hash, wait for result.
   typedef enum logic [1:0] {P_RD, P_WAIT, P_REQ, P_RES} phase_t;

   localparam logic [ADDR_W-1:0] DICT_FIRST = ADDR_W'(DICT_START);
   localparam logic [ADDR_W-1:0] DICT_LAST  = ADDR_W'(DICT_START + DICT_SIZE - 1);
   localparam logic [7:0]        LAT        = 8'(MEM_LAT);

   generate
      if (MEM_LAT < 1 || MEM_LAT > 255 || BRUTE_MAX < 0 || DICT_SIZE < 0 ||
          (DICT_SIZE > 0 && DICT_START + DICT_SIZE - 1 >= (1 << ADDR_W))) begin : g_bad_cfg
         $error("crack_sequencer: illegal parameter combination");
      end
   endgenerate

   state_t             st, st_n;
   phase_t             ph, ph_n;
   logic [7:0]         lat, lat_n;
   logic [ADDR_W-1:0]  addr, addr_n;
   logic [DATA_W-1:0]  target, target_n;
   logic [DATA_W-1:0]  cand, cand_n;
   logic [DATA_W-1:0]  fw_n;
   logic [31:0]        att_n;
   logic [2:0]         led_n;
   logic               done_n;
   logic               exhaust;
`ifdef CRACK_BRUTE_EN
   logic [31:0]        cnt, cnt_n, cnt_inc;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         st         <= S_IDLE;
         ph         <= P_RD;
         lat        <= '0;
         addr       <= '0;
         target     <= '0;
         cand       <= '0;
         found_word <= '0;
         attempts   <= '0;
         led        <= '0;
         done       <= 1'b0;
`ifdef CRACK_BRUTE_EN
         cnt        <= '0;
`endif
      end else begin
         st         <= st_n;
         ph         <= ph_n;
         lat        <= lat_n;
         addr       <= addr_n;
         target     <= target_n;
         cand       <= cand_n;
         found_word <= fw_n;
         attempts   <= att_n;
         led        <= led_n;
         done       <= done_n;
`ifdef CRACK_BRUTE_EN
         cnt        <= cnt_n;
`endif
      end
   end

   always_comb begin
      st_n     = st;
      ph_n     = ph;
      lat_n    = lat;
      addr_n   = addr;
      target_n = target;
      cand_n   = cand;
      fw_n     = found_word;
      att_n    = attempts;
      exhaust  = 1'b0;
`ifdef CRACK_BRUTE_EN
      cnt_n    = cnt;
      cnt_inc  = cnt + 32'd1;
`endif
      case (st)
         S_IDLE, S_SUCCESS, S_FAIL: begin
            if (start) begin
               fw_n   = '0;
               att_n  = '0;
               st_n   = S_LOAD;
               ph_n   = P_RD;
               addr_n = '0;
            end
         end
         S_LOAD, S_DICT, S_BRUTE: begin
            case (ph)
               P_RD: begin
                  ph_n  = P_WAIT;
                  lat_n = 8'd1;
               end
               P_WAIT: begin
                  if (lat != LAT) begin
                     lat_n = lat + 8'd1;
                  end else if (st == S_LOAD) begin
                     target_n = mem_rdata;
                     if (DICT_SIZE == 0) begin
                        exhaust = 1'b1;
                     end else begin
                        st_n   = S_DICT;
                        ph_n   = P_RD;
                        addr_n = DICT_FIRST;
                     end
                  end else begin
                     cand_n = mem_rdata;
                     ph_n   = P_REQ;
                  end
               end
               P_REQ: begin
                  if (hash_ack) ph_n = P_RES;
               end
               P_RES: begin
                  if (hash_valid) begin
                     att_n = attempts + 32'd1;
                     if (hash_out == target) begin
                        fw_n = cand;
                        st_n = S_SUCCESS;
                     end else if (st == S_DICT) begin
                        if (addr == DICT_LAST) begin
                           exhaust = 1'b1;
                        end else begin
                           addr_n = addr + ADDR_W'(1);
                           ph_n   = P_RD;
                        end
                     end
`ifdef CRACK_BRUTE_EN
                     else begin
                        cnt_n  = cnt_inc;
                        cand_n = DATA_W'(cnt_inc);
                        if (cnt_inc == 32'(BRUTE_MAX)) st_n = S_FAIL;
                        else                           ph_n = P_REQ;
                     end
`endif
                  end
               end
            endcase
            // Out of dictionary words: fall through to the brute pass when it exists.
            if (exhaust) begin
`ifdef CRACK_BRUTE_EN
               if (BRUTE_MAX == 0) begin
                  st_n = S_FAIL;
               end else begin
                  st_n   = S_BRUTE;
                  ph_n   = P_REQ;
                  cand_n = '0;
                  cnt_n  = '0;
               end
`else
               st_n = S_FAIL;
`endif
            end
            // Abort outranks a same-cycle result, including a match.
            if (abort) begin
               st_n  = S_IDLE;
               ph_n  = P_RD;
               att_n = attempts;
               fw_n  = found_word;
            end
         end
         default: st_n = S_IDLE;
      endcase

      case (st)
         S_IDLE:                  led_n = 3'b011;
         S_LOAD, S_DICT, S_BRUTE: led_n = 3'b100;
         S_SUCCESS:               led_n = 3'b010;
         S_FAIL:                  led_n = 3'b001;
         default:                 led_n = 3'b000;
      endcase
      done_n = (st_n == S_SUCCESS || st_n == S_FAIL) && !(st == S_SUCCESS || st == S_FAIL);
   end

   assign state     = st;
   assign busy      = (st == S_LOAD) || (st == S_DICT) || (st == S_BRUTE);
   assign found     = (st == S_SUCCESS);
   assign mem_rd_en = (st == S_LOAD || st == S_DICT) && (ph == P_RD);
   assign mem_addr  = addr;
   assign hash_req  = (st == S_DICT || st == S_BRUTE) && (ph == P_REQ);
   assign hash_in   = cand;

endmodule

// File: tb/tb_crack_sequencer.sv
// Directed bench for crack_sequencer with a latency-3 BRAM model and a xor-key hash engine model.
module tb_crack_sequencer;
   localparam int DW = 128;
   localparam int AW = 8;
   localparam int ML = 3;
   localparam logic [DW-1:0] KEY  = 128'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_9696_6969;
   localparam logic [DW-1:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
   localparam logic [DW-1:0] W1   = 128'h0123_4567_89AB_CDEF_0000_0000_0000_1111;
   localparam logic [DW-1:0] W2   = 128'h0123_4567_89AB_CDEF_0000_0000_0000_2222;
   localparam logic [DW-1:0] W3   = 128'h0123_4567_89AB_CDEF_0000_0000_0000_3333;
   localparam logic [DW-1:0] NONE = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
`ifdef CRACK_BRUTE_EN
   localparam logic          BRUTE    = 1'b1;
   localparam logic [2:0]    T3_STATE = 3'd4;
   localparam logic [31:0]   T3_ATT   = 32'd11;
   localparam logic [DW-1:0] T3_FW    = 128'd7;
   localparam logic [31:0]   T4_ATT   = 32'd13;
   localparam logic [DW-1:0] AB_TGT   = 128'd5 ^ KEY;
   localparam logic [2:0]    AB_STATE = 3'd3;
   localparam logic [31:0]   AB_ATT   = 32'd8;
`else
   localparam logic          BRUTE    = 1'b0;
   localparam logic [2:0]    T3_STATE = 3'd5;
   localparam logic [31:0]   T3_ATT   = 32'd3;
   localparam logic [DW-1:0] T3_FW    = 128'd0;
   localparam logic [31:0]   T4_ATT   = 32'd3;
   localparam logic [DW-1:0] AB_TGT   = W2 ^ KEY;
   localparam logic [2:0]    AB_STATE = 3'd2;
   localparam logic [31:0]   AB_ATT   = 32'd1;
`endif

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
   logic mem_rd_en, hash_req, busy, done, found;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata, hash_in, found_word;
   logic hash_ack = 1'b0, hash_valid = 1'b0;
   logic [DW-1:0] hash_out = '0;
   logic [2:0] state, led;
   logic [31:0] attempts;

   int checks = 0, errors = 0;

   crack_sequencer #(.DATA_W(DW), .ADDR_W(AW), .DICT_START(1), .DICT_SIZE(3),
                     .BRUTE_MAX(10), .MEM_LAT(ML)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .hash_req(hash_req), .hash_ack(hash_ack), .hash_in(hash_in),
      .hash_valid(hash_valid), .hash_out(hash_out),
      .state(state), .led(led), .busy(busy), .done(done), .found(found),
      .found_word(found_word), .attempts(attempts));

   always #5 clk = ~clk;

   // BRAM: data valid exactly ML cycles after the strobe, junk otherwise.
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] p1 = '0, p2 = '0, p3 = '0;
   logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
   always @(posedge clk) begin
      v1 <= mem_rd_en; p1 <= mem[mem_addr];
      v2 <= v1;        p2 <= p1;
      v3 <= v2;        p3 <= p2;
   end
   assign mem_rdata = v3 ? p3 : JUNK;

   // Hash engine: ack after ack_dly cycles of request, result two cycles after transfer.
   int ack_dly = 0, req_cnt = 0, res_cnt = 0, err_stable = 0, err_overlap = 0;
   logic pend = 1'b0, hold = 1'b0, saw3 = 1'b0;
   logic [DW-1:0] pend_dat = '0, held_in = '0;
   logic [DW-1:0] acc_log [$];
   always @(posedge clk) begin
      hash_valid <= 1'b0;
      if (state == 3'd3) saw3 <= 1'b1;
      if (hold && hash_req && hash_in !== held_in) err_stable <= err_stable + 1;
      hold    <= hash_req && !hash_ack;
      held_in <= hash_in;
      if (pend) begin
         if (res_cnt <= 1) begin
            hash_valid <= 1'b1;
            hash_out   <= pend_dat ^ KEY;
            pend       <= 1'b0;
         end else res_cnt <= res_cnt - 1;
      end
      if (hash_req && hash_ack) begin
         if (pend) err_overlap <= err_overlap + 1;
         pend <= 1'b1; pend_dat <= hash_in; res_cnt <= 2;
         hash_ack <= 1'b0; req_cnt <= 0;
         acc_log.push_back(hash_in);
      end else if (hash_req) begin
         if (req_cnt >= ack_dly) hash_ack <= 1'b1;
         else                    req_cnt  <= req_cnt + 1;
      end else begin
         hash_ack <= 1'b0; req_cnt <= 0;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic setup_mem(input logic [DW-1:0] tgt);
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[0] = tgt; mem[1] = W1; mem[2] = W2; mem[3] = W3;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s, input string nm);
      int n = 0;
      while (state !== s && n < 400) begin tick(); n++; end
      checks++;
      if (state !== s) begin errors++; $display("FAIL %s timeout state=%0d want %0d", nm, state, s); end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; tick(); tick();
      checks++;
      if ({state, led, busy, done, found, hash_req, mem_rd_en} !== 11'd0) begin
         errors++; $display("FAIL reset_flags got %0h want 0", {state, led, busy, done, found, hash_req, mem_rd_en});
      end
      checks++;
      if (attempts !== 32'd0 || found_word !== '0) begin
         errors++; $display("FAIL reset_regs attempts=%0d found_word=%0h want 0", attempts, found_word);
      end
      reset = 1'b1; tick();
      checks++;
      if (led !== 3'b011 || state !== 3'd0) begin errors++; $display("FAIL reset_led led=%b state=%0d want 011/0", led, state); end
   endtask

   task automatic test_dict_match();
      setup_mem(W2 ^ KEY); ack_dly = 1;
      pulse_start();
      checks++;
      if (state !== 3'd1 || led !== 3'b011 || busy !== 1'b1) begin
         errors++; $display("FAIL start_load state=%0d led=%b busy=%b want 1/011/1", state, led, busy);
      end
      tick();
      checks++;
      if (led !== 3'b100) begin errors++; $display("FAIL busy_led led=%b want 100", led); end
      wait_state(3'd4, "dict_success");
      checks++;
      if (done !== 1'b1 || found !== 1'b1) begin errors++; $display("FAIL dict_done done=%b found=%b want 1/1", done, found); end
      checks++;
      if (found_word !== W2 || attempts !== 32'd2) begin
         errors++; $display("FAIL dict_result word=%0h attempts=%0d want %0h/2", found_word, attempts, W2);
      end
      tick();
      checks++;
      if (done !== 1'b0 || led !== 3'b010 || state !== 3'd4) begin
         errors++; $display("FAIL dict_after done=%b led=%b state=%0d want 0/010/4", done, led, state);
      end
      idle(5);
   endtask

   task automatic test_brute_match();
      setup_mem(128'd7 ^ KEY); ack_dly = 0;
      pulse_start();
      wait_state(T3_STATE, "brute_end");
      checks++;
      if (attempts !== T3_ATT || found_word !== T3_FW) begin
         errors++; $display("FAIL brute_result attempts=%0d word=%0h want %0d/%0h", attempts, found_word, T3_ATT, T3_FW);
      end
      idle(5);
   endtask

   task automatic test_exhaust();
      setup_mem(NONE ^ KEY); ack_dly = 0;
      pulse_start();
      wait_state(3'd5, "exhaust_fail");
      checks++;
      if (attempts !== T4_ATT || done !== 1'b1 || found !== 1'b0) begin
         errors++; $display("FAIL exhaust_result attempts=%0d done=%b found=%b want %0d/1/0", attempts, done, found, T4_ATT);
      end
      tick();
      checks++;
      if (led !== 3'b001) begin errors++; $display("FAIL exhaust_led led=%b want 001", led); end
      checks++;
      if (saw3 !== BRUTE) begin errors++; $display("FAIL brute_state_seen got %b want %b", saw3, BRUTE); end
      idle(5);
   endtask

   task automatic test_handshake();
      int n = 0;
      logic [DW-1:0] first_in;
      setup_mem(W2 ^ KEY); ack_dly = 4;
      acc_log.delete(); err_stable = 0; err_overlap = 0;
      pulse_start();
      while (hash_req !== 1'b1 && n < 400) begin tick(); n++; end
      first_in = hash_in;
      checks++;
      if (first_in !== W1) begin errors++; $display("FAIL hs_first_in got %0h want %0h", first_in, W1); end
      idle(3);
      checks++;
      if (hash_req !== 1'b1 || hash_in !== W1) begin
         errors++; $display("FAIL hs_hold req=%b in=%0h want 1/%0h", hash_req, hash_in, W1);
      end
      wait_state(3'd4, "hs_success");
      checks++;
      if (err_stable !== 0 || err_overlap !== 0) begin
         errors++; $display("FAIL hs_protocol unstable=%0d overlap=%0d want 0/0", err_stable, err_overlap);
      end
      checks++;
      if (acc_log.size() !== 2) begin
         errors++; $display("FAIL hs_count got %0d want 2", acc_log.size());
      end else begin
         checks++;
         if (acc_log[0] !== W1 || acc_log[1] !== W2) begin
            errors++; $display("FAIL hs_words got %0h,%0h want %0h,%0h", acc_log[0], acc_log[1], W1, W2);
         end
      end
      idle(5);
   endtask

   task automatic test_abort();
      int n = 0;
      setup_mem(AB_TGT); ack_dly = 0;
      pulse_start();
      while (!(hash_valid === 1'b1 && hash_out === AB_TGT) && n < 400) begin tick(); n++; end
      checks++;
      if (state !== AB_STATE) begin errors++; $display("FAIL abort_where state=%0d want %0d", state, AB_STATE); end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++;
      if (state !== 3'd0 || found !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL abort_idle state=%0d found=%b busy=%b done=%b want 0/0/0/0", state, found, busy, done);
      end
      checks++;
      if (attempts !== AB_ATT) begin errors++; $display("FAIL abort_attempts got %0d want %0d", attempts, AB_ATT); end
      abort = 1'b1; idle(3); abort = 1'b0;
      checks++;
      if (state !== 3'd0 || attempts !== AB_ATT) begin
         errors++; $display("FAIL abort_idle_hold state=%0d attempts=%0d want 0/%0d", state, attempts, AB_ATT);
      end
      idle(5);
   endtask

   task automatic test_busy_start_and_reset();
      setup_mem(W3 ^ KEY); ack_dly = 2;
      pulse_start();
      wait_state(3'd2, "bs_dict");
      pulse_start();
      checks++;
      if (state !== 3'd2 || busy !== 1'b1) begin
         errors++; $display("FAIL busy_start state=%0d busy=%b want 2/1", state, busy);
      end
      wait_state(3'd4, "bs_success");
      checks++;
      if (attempts !== 32'd3 || found_word !== W3) begin
         errors++; $display("FAIL bs_result attempts=%0d word=%0h want 3/%0h", attempts, found_word, W3);
      end
      idle(5);
      pulse_start();
      wait_state(3'd2, "rst_dict");
      reset = 1'b0; tick();
      checks++;
      if (state !== 3'd0 || led !== 3'b000 || attempts !== 32'd0 || hash_req !== 1'b0 || found_word !== '0) begin
         errors++; $display("FAIL mid_reset state=%0d led=%b attempts=%0d req=%b want 0/000/0/0", state, led, attempts, hash_req);
      end
      reset = 1'b1; idle(10);
      checks++;
      if (state !== 3'd0 || attempts !== 32'd0) begin
         errors++; $display("FAIL post_reset state=%0d attempts=%0d want 0/0", state, attempts);
      end
   endtask

   initial begin
      test_reset();
      test_dict_match();
      test_brute_match();
      test_exhaust();
      test_handshake();
      test_abort();
      test_busy_start_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
